// File: rtl/uart_pkg.sv
// Shared definitions for the UART register responder.
//   kCmdWrite / kCmdRead : opcode bytes of the register protocol
//   resp_state_t         : responder FSM states
//   addr_in_range()      : full 8-bit address check against the register count
package uart_pkg;

  localparam logic [7:0] kCmdWrite = 8'h57;  // 'W'
  localparam logic [7:0] kCmdRead  = 8'h52;  // 'R'

  typedef enum logic [1:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    RESPOND
  } resp_state_t;

  // The whole byte is compared, so addresses whose low bits alias a valid
  // register index are still rejected.
  function automatic logic addr_in_range(input logic [7:0] addr, input int num_regs);
    return 32'(addr) < num_regs;
  endfunction

endpackage

// File: rtl/uart_reg_responder.sv
// Byte-stream register read/write responder sitting behind the UART.
// Decodes 'W',addr,data (reply kAckByte) and 'R',addr (reply regs[addr]);
// anything malformed or out of range replies kErrByte. One reply per command.
// Ports:
//   clk, rst_n        system clock; asynchronous active-low reset
//   rx_data, rx_valid received byte and its single-cycle strobe (no backpressure)
//   tx_data, tx_valid reply byte, held stable until accepted
//   tx_ready          transmitter accepts the byte on tx_valid && tx_ready
//   regs_out          flat register file, reg i at [8*i+:8]
//   overrun_count     saturating count of bytes dropped while a reply is pending
module uart_reg_responder
  import uart_pkg::*;
#(
  parameter int         kNumRegs       = 16,
  parameter int         kTimeoutCycles = 1_000_000,
  parameter logic [7:0] kAckByte       = 8'h4B,
  parameter logic [7:0] kErrByte       = 8'h45
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [kNumRegs*8-1:0] regs_out,
  output logic [7:0]            overrun_count
);

  localparam int AW = $clog2(kNumRegs);
  localparam int CW = $clog2(kTimeoutCycles) + 1;
  localparam logic [CW-1:0] kCntLast = CW'(kTimeoutCycles - 1);

  resp_state_t   state_reg, state_next;
  logic          is_write_reg, is_write_next;
  logic [7:0]    addr_reg, addr_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    ovr_reg, ovr_next;
  logic          wr_en;
  logic [7:0]    regs_reg [kNumRegs];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      is_write_reg <= 1'b0;
      addr_reg     <= '0;
      tx_data_reg  <= '0;
      cnt_reg      <= '0;
      ovr_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      is_write_reg <= is_write_next;
      addr_reg     <= addr_next;
      tx_data_reg  <= tx_data_next;
      cnt_reg      <= cnt_next;
      ovr_reg      <= ovr_next;
    end
  end

  // Plain flops rather than RAM: every register is visible in parallel on regs_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < kNumRegs; i++) regs_reg[i] <= '0;
    end else if (wr_en) begin
      regs_reg[addr_reg[AW-1:0]] <= rx_data;
    end
  end

  always_comb begin
    state_next    = state_reg;
    is_write_next = is_write_reg;
    addr_next     = addr_reg;
    tx_data_next  = tx_data_reg;
    ovr_next      = ovr_reg;
    cnt_next      = '0;     // cleared on any strobe and outside the mid-frame states
    wr_en         = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == kCmdWrite || rx_data == kCmdRead) begin
            is_write_next = (rx_data == kCmdWrite);
            state_next    = GET_ADDR;
          end else begin
            tx_data_next = kErrByte;
            state_next   = RESPOND;
          end
        end
      end

      GET_ADDR: begin
        if (rx_valid) begin
          addr_next = rx_data;
          if (is_write_reg) begin
            state_next = GET_DATA;
          end else begin
            tx_data_next = addr_in_range(rx_data, kNumRegs) ? regs_reg[rx_data[AW-1:0]] : kErrByte;
            state_next   = RESPOND;
          end
        end else if (cnt_reg == kCntLast) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      GET_DATA: begin
        if (rx_valid) begin
          if (addr_in_range(addr_reg, kNumRegs)) begin
            wr_en        = 1'b1;
            tx_data_next = kAckByte;
          end else begin
            tx_data_next = kErrByte;
          end
          state_next = RESPOND;
        end else if (cnt_reg == kCntLast) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      RESPOND: begin
        // No input buffering: anything arriving now is lost and only counted.
        if (rx_valid && ovr_reg != 8'hFF) ovr_next = ovr_reg + 8'd1;
        if (tx_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign tx_valid      = (state_reg == RESPOND);
  assign tx_data       = tx_data_reg;
  assign overrun_count = ovr_reg;

  generate
    for (genvar gi = 0; gi < kNumRegs; gi++) begin : g_regs_out
      assign regs_out[8*gi +: 8] = regs_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_uart_reg_responder.sv
module tb_uart_reg_responder;

  localparam int NREGS = 16;
  localparam int TOUT  = 100;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_data = '0;
  logic             rx_valid = 1'b0;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b1;
  logic [NREGS*8-1:0] regs_out;
  logic [7:0]       overrun_count;

  int total = 0;
  int bad   = 0;

  uart_reg_responder #(
    .kNumRegs(NREGS),
    .kTimeoutCycles(TOUT),
    .kAckByte(8'h4B),
    .kErrByte(8'h45)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .regs_out(regs_out),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model: a frame of collected bytes ----------------
  logic [7:0] m_regs [NREGS];
  logic [7:0] m_frame [$];
  int         m_idle;
  bit         m_pend;
  logic [7:0] m_reply;
  int         m_ovr;

  task automatic m_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_frame.delete();
    m_idle  = 0;
    m_pend  = 0;
    m_reply = 8'h00;
    m_ovr   = 0;
  endtask

  task automatic m_reply_with(input logic [7:0] b);
    m_pend  = 1;
    m_reply = b;
    m_frame.delete();
    m_idle  = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else if (m_pend) begin
      if (rx_valid && m_ovr < 255) m_ovr++;
      if (tx_ready) m_pend = 0;
    end else if (rx_valid) begin
      m_frame.push_back(rx_data);
      m_idle = 0;
      if (m_frame[0] != 8'h57 && m_frame[0] != 8'h52)
        m_reply_with(8'h45);
      else if (m_frame[0] == 8'h52 && m_frame.size() == 2)
        m_reply_with(m_frame[1] < NREGS ? m_regs[m_frame[1]] : 8'h45);
      else if (m_frame[0] == 8'h57 && m_frame.size() == 3) begin
        if (m_frame[1] < NREGS) begin
          m_regs[m_frame[1]] = m_frame[2];
          m_reply_with(8'h4B);
        end else begin
          m_reply_with(8'h45);
        end
      end
    end else if (m_frame.size() > 0) begin
      m_idle++;
      if (m_idle >= TOUT) begin
        m_frame.delete();
        m_idle = 0;
      end
    end
  end

  // ---------------- comparison helpers ----------------
  task automatic chk(input string name, input logic [NREGS*8-1:0] act, input logic [NREGS*8-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREGS*8-1:0] m_flat();
    logic [NREGS*8-1:0] v;
    for (int i = 0; i < NREGS; i++) v[8*i +: 8] = m_regs[i];
    return v;
  endfunction

  // Every cycle: outputs against the model, sampled on the falling edge.
  always @(negedge clk) begin
    chk("tx_valid", {127'b0, tx_valid}, {127'b0, m_pend});
    if (m_pend) chk("tx_data", {120'b0, tx_data}, {120'b0, m_reply});
    chk("regs_out", regs_out, m_flat());
    chk("overrun_count", {120'b0, overrun_count}, 128'(m_ovr));
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [NREGS*8-1:0] snap;

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("reset_tx_valid", {127'b0, tx_valid}, 128'd0);
    chk("reset_regs", regs_out, 128'd0);
    chk("reset_tx_data", {120'b0, tx_data}, 128'd0);
    $display("txn reset done");

    // Write reg 3
    send(8'h57); send(8'h03); send(8'hA5);
    chk("wr_tx_valid", {127'b0, tx_valid}, 128'd1);
    chk("wr_ack", {120'b0, tx_data}, 128'h4B);
    chk("wr_reg3", {120'b0, regs_out[31:24]}, 128'hA5);
    $display("txn W 03 A5 -> tx %02h", tx_data);
    idle(2);

    // Read reg 3
    snap = regs_out;
    send(8'h52); send(8'h03);
    chk("rd_reg3", {120'b0, tx_data}, 128'hA5);
    chk("rd_regs_same", regs_out, snap);
    $display("txn R 03 -> tx %02h", tx_data);
    idle(2);

    // Bad opcode
    send(8'h41);
    chk("bad_op", {120'b0, tx_data}, 128'h45);
    $display("txn 41 -> tx %02h", tx_data);
    idle(2);

    // Read out of range
    send(8'h52); send(8'h10);
    chk("rd_oor", {120'b0, tx_data}, 128'h45);
    $display("txn R 10 -> tx %02h", tx_data);
    idle(2);

    // Write out of range
    snap = regs_out;
    send(8'h57); send(8'h20); send(8'h11);
    chk("wr_oor", {120'b0, tx_data}, 128'h45);
    idle(1);
    chk("wr_oor_regs", regs_out, snap);
    $display("txn W 20 11 -> tx 45 expected");
    idle(1);

    // Stall with overruns
    tx_ready = 1'b0;
    send(8'h52); send(8'h03);
    for (int c = 0; c < 50; c++) begin
      if (c == 10 || c == 20 || c == 30) send(8'h99); else idle(1);
    end
    chk("stall_valid", {127'b0, tx_valid}, 128'd1);
    chk("stall_data", {120'b0, tx_data}, 128'hA5);
    chk("overrun3", {120'b0, overrun_count}, 128'd3);
    tx_ready = 1'b1;
    idle(1);
    chk("stall_release", {127'b0, tx_valid}, 128'd0);
    $display("txn stall 50 cycles overrun=%0d", overrun_count);
    idle(1);

    // Byte arriving on the expiry cycle still counts
    send(8'h57); send(8'h01);
    idle(TOUT - 1);
    send(8'h77);
    chk("late_ack", {120'b0, tx_data}, 128'h4B);
    chk("late_reg1", {120'b0, regs_out[15:8]}, 128'h77);
    $display("txn W 01 77 after %0d idle -> tx %02h", TOUT - 1, tx_data);
    idle(2);

    // Abandoned frame
    send(8'h57); send(8'h02);
    idle(TOUT);
    send(8'h52); send(8'h02);
    chk("timeout_read", {120'b0, tx_data}, 128'h00);
    $display("txn timeout then R 02 -> tx %02h", tx_data);
    idle(2);

    // Async reset in the middle of a write
    send(8'h57); send(8'h05);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", {127'b0, tx_valid}, 128'd0);
    chk("arst_regs", regs_out, 128'd0);
    chk("arst_ovr", {120'b0, overrun_count}, 128'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h57); send(8'h02); send(8'h33);
    chk("post_rst_ack", {120'b0, tx_data}, 128'h4B);
    chk("post_rst_reg2", {120'b0, regs_out[23:16]}, 128'h33);
    $display("txn reset mid-write, then W 02 33 -> tx %02h", tx_data);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        idle($urandom_range(TOUT - 10, TOUT + 10));
      end else begin
        tx_ready = ($urandom_range(0, 9) < 7);
        rx_valid = ($urandom_range(0, 9) < 4);
        case ($urandom_range(0, 3))
          0: rx_data = 8'h57;
          1: rx_data = 8'h52;
          2: rx_data = 8'($urandom_range(0, 20));
          default: rx_data = 8'($urandom_range(0, 255));
        endcase
        if (rx_valid && tx_valid) $display("txn rand %0d overrun byte %02h", i, rx_data);
        else if (rx_valid) $display("txn rand %0d rx %02h", i, rx_data);
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
